// File: rtl/dlx_regfile_wr_pkg.sv
// Shared constants and small decode helpers for the DLX register file write side.
package dlx_regfile_wr_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;
  localparam int DATA_W     = 32;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  function automatic logic [3:0] dec2_4(input logic [1:0] a);
    dec2_4 = 4'b0001 << a;
  endfunction

  function automatic logic [7:0] dec3_8(input logic [2:0] a);
    dec3_8 = 8'b0000_0001 << a;
  endfunction

endpackage

// File: rtl/dlx_regfile_wr_if.sv
// Writeback and read-port bundle between the pipeline and the register file.
interface dlx_regfile_wr_if import dlx_regfile_wr_pkg::*; #(
  parameter int WIDTH = DATA_W,
  parameter int NREG  = NUM_REGS
) ();

  logic                  wr_en;
  logic [REG_ADDR_W-1:0] wr_addr;
  logic [WIDTH-1:0]      wr_data;
  logic [REG_ADDR_W-1:0] rd_addr_a;
  logic [REG_ADDR_W-1:0] rd_addr_b;
  logic [WIDTH-1:0]      rd_data_a;
  logic [WIDTH-1:0]      rd_data_b;
  logic [NREG-1:0]       wr_onehot;

  modport master (
    output wr_en, wr_addr, wr_data, rd_addr_a, rd_addr_b,
    input  rd_data_a, rd_data_b, wr_onehot
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rd_addr_a, rd_addr_b,
    output rd_data_a, rd_data_b, wr_onehot
  );

endinterface

// File: rtl/dlx_regfile_wr_decoder5_32.sv
// 5-to-32 write-enable decoder: a 3-to-8 on addr[4:2] ANDed with an en-gated 2-to-4 on addr[1:0].
// Purely combinational; row 0 is forced low so R0 can never be written.
module decoder5_32 import dlx_regfile_wr_pkg::*; (
  input  logic                  en,
  input  logic [REG_ADDR_W-1:0] addr,
  output logic [NUM_REGS-1:0]   onehot
);

  logic [3:0] lo;
  logic [7:0] hi;

  assign lo = dec2_4(addr[1:0]) & {4{en}};
  assign hi = dec3_8(addr[4:2]);

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_row
    if (i == 0) begin : g_zero
      assign onehot[i] = 1'b0;
    end else begin : g_dec
      assign onehot[i] = hi[i / 4] & lo[i % 4];
    end
  end

endmodule

// File: rtl/dlx_regfile_wr_mux.sv
// Gate-level single-bit muxes used by the register file read path.
// mux32_1 is a five-level tree of mux2_1 cells, select bit 0 at the leaves.
module mux2_1 (
  input  logic a,
  input  logic b,
  input  logic sel,
  output logic y
);

  assign y = (a & ~sel) | (b & sel);

endmodule

module mux32_1 (
  input  logic [31:0] d,
  input  logic [4:0]  sel,
  output logic        y
);

  logic [15:0] l1;
  logic [7:0]  l2;
  logic [3:0]  l3;
  logic [1:0]  l4;

  for (genvar i = 0; i < 16; i++) begin : g_l1
    mux2_1 u_m (.a(d[2*i]), .b(d[2*i+1]), .sel(sel[0]), .y(l1[i]));
  end
  for (genvar i = 0; i < 8; i++) begin : g_l2
    mux2_1 u_m (.a(l1[2*i]), .b(l1[2*i+1]), .sel(sel[1]), .y(l2[i]));
  end
  for (genvar i = 0; i < 4; i++) begin : g_l3
    mux2_1 u_m (.a(l2[2*i]), .b(l2[2*i+1]), .sel(sel[2]), .y(l3[i]));
  end
  for (genvar i = 0; i < 2; i++) begin : g_l4
    mux2_1 u_m (.a(l3[2*i]), .b(l3[2*i+1]), .sel(sel[3]), .y(l4[i]));
  end
  mux2_1 u_root (.a(l4[0]), .b(l4[1]), .sel(sel[4]), .y(y));

endmodule

// File: rtl/dlx_regfile_wr.sv
// DLX 32x32 register file write side with two combinational read ports and write-through bypass.
// Writes land on the rising edge; reads and bypass are zero-latency; no handshake.
module dlx_regfile_wr import dlx_regfile_wr_pkg::*; #(
  parameter int WIDTH = DATA_W,
  parameter int NREG  = NUM_REGS
) (
  input  logic             clk,
  input  logic             reset,
  dlx_regfile_wr_if.slave  bus
);

  logic [NREG-1:0]  onehot;
  logic [NREG-1:0]  col [WIDTH];
  logic [WIDTH-1:0] base_a;
  logic [WIDTH-1:0] base_b;
  logic             hit_a;
  logic             hit_b;

  decoder5_32 u_dec (
    .en     (bus.wr_en),
    .addr   (bus.wr_addr),
    .onehot (onehot)
  );

  assign bus.wr_onehot = onehot;

  // R0 has no storage; its mux input is hardwired to zero.
  for (genvar b = 0; b < WIDTH; b++) begin : g_r0
    assign col[b][0] = 1'b0;
  end

  for (genvar i = 1; i < NREG; i++) begin : g_row
    logic [WIDTH-1:0] q;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        q <= '0;
      end else if (onehot[i]) begin
        q <= bus.wr_data;
      end
    end

    for (genvar b = 0; b < WIDTH; b++) begin : g_bit
      assign col[b][i] = q[b];
    end
  end

  assign hit_a = bus.wr_en & (bus.wr_addr == bus.rd_addr_a) & (bus.rd_addr_a != REG_ZERO);
  assign hit_b = bus.wr_en & (bus.wr_addr == bus.rd_addr_b) & (bus.rd_addr_b != REG_ZERO);

  for (genvar b = 0; b < WIDTH; b++) begin : g_rd
    mux32_1 u_mux_a (.d(col[b]), .sel(bus.rd_addr_a), .y(base_a[b]));
    mux32_1 u_mux_b (.d(col[b]), .sel(bus.rd_addr_b), .y(base_b[b]));

    mux2_1 u_byp_a (.a(base_a[b]), .b(bus.wr_data[b]), .sel(hit_a), .y(bus.rd_data_a[b]));
    mux2_1 u_byp_b (.a(base_b[b]), .b(bus.wr_data[b]), .sel(hit_b), .y(bus.rd_data_b[b]));
  end

endmodule
